// File: rtl/cla_self_test_if.sv
// Adder-facing port bundle for cla_self_test.
//   A_drv/B_drv/Cin_drv : operands driven into the adder's input registers
//   S_obs/Cout_obs      : registered sum/carry observed from the adder
// master = the self-test engine, slave = the adder under test.
interface cla_self_test_if #(
  parameter int unsigned WIDTH = 5
);
  logic [WIDTH-1:0] A_drv;
  logic [WIDTH-1:0] B_drv;
  logic             Cin_drv;
  logic [WIDTH-1:0] S_obs;
  logic             Cout_obs;

  modport master (
    output A_drv,
    output B_drv,
    output Cin_drv,
    input  S_obs,
    input  Cout_obs
  );

  modport slave (
    input  A_drv,
    input  B_drv,
    input  Cin_drv,
    output S_obs,
    output Cout_obs
  );
endinterface

// File: rtl/cla_self_test.sv
// Exhaustive stimulus/response engine for a registered WIDTH-bit adder.
// Sweeps every {Cin,B,A} vector (A fastest), compares the adder result LATENCY edges later
// against A+B+Cin and reports pass, error count and the first failing vector index.
// Ports:
//   CLK, RST        : clock, asynchronous active-high reset
//   start           : begin a sweep (honoured in IDLE or DONE only)
//   adder           : drive/observe bundle towards the adder (master side)
//   busy, done      : sweep in progress / results valid
//   pass            : no mismatches in the last sweep (valid with done)
//   err_count       : number of mismatching vectors
//   first_err_vec   : index of the first mismatching vector
//   first_err_valid : first_err_vec holds a captured mismatch
module cla_self_test #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  cla_self_test_if.master      adder,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH:0]     first_err_vec,
  output logic                 first_err_valid
);

  localparam int unsigned VecW  = 2 * WIDTH + 1;
  localparam int unsigned Depth = LATENCY + 1;
  localparam int unsigned CntW  = $clog2(Depth + 2);
  localparam logic [VecW-1:0] LastVec   = '1;
  // DONE is entered one edge after the last valid entry leaves the delay line.
  localparam logic [CntW-1:0] LastDrain = CntW'(Depth);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [VecW-1:0]     vec_q, vec_d;
  logic [CntW-1:0]     drain_q, drain_d;
  logic [VecW:0]       err_q, err_d;
  logic [VecW-1:0]     fev_q, fev_d;
  logic                fevalid_q, fevalid_d;
  logic                pass_q, pass_d;

  // Delay line: expected result and vector index travel with a valid flag.
  logic [Depth-1:0]    dl_valid_q;
  logic [WIDTH:0]      dl_exp_q [Depth];
  logic [VecW-1:0]     dl_idx_q [Depth];

  logic                push_valid;
  logic [WIDTH:0]      push_exp;
  logic [WIDTH:0]      obs;
  logic                mismatch;

  assign obs      = {adder.Cout_obs, adder.S_obs};
  assign mismatch = dl_valid_q[Depth-1] && (obs != dl_exp_q[Depth-1]);

  // Expected sum of whatever vector is being driven next.
  assign push_exp = {1'b0, vec_d[WIDTH-1:0]} + {1'b0, vec_d[2*WIDTH-1:WIDTH]} +
                    {{WIDTH{1'b0}}, vec_d[2*WIDTH]};

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    drain_d    = drain_q;
    err_d      = err_q;
    fev_d      = fev_q;
    fevalid_d  = fevalid_q;
    pass_d     = pass_q;
    push_valid = 1'b0;

    if (mismatch) begin
      err_d = err_q + 1'b1;
      if (!fevalid_q) begin
        fevalid_d = 1'b1;
        fev_d     = dl_idx_q[Depth-1];
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StRun;
          vec_d      = '0;
          push_valid = 1'b1;
          err_d      = '0;
          fev_d      = '0;
          fevalid_d  = 1'b0;
          pass_d     = 1'b0;
        end
      end
      StRun: begin
        vec_d      = vec_q + 1'b1;
        push_valid = 1'b1;
        if (vec_d == LastVec) begin
          state_d = StDrain;
          drain_d = '0;
        end
      end
      StDrain: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == LastDrain) begin
          state_d = StDone;
          pass_d  = (err_d == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      vec_q     <= '0;
      drain_q   <= '0;
      err_q     <= '0;
      fev_q     <= '0;
      fevalid_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      drain_q   <= drain_d;
      err_q     <= err_d;
      fev_q     <= fev_d;
      fevalid_q <= fevalid_d;
      pass_q    <= pass_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dl_valid_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        dl_exp_q[i] <= '0;
        dl_idx_q[i] <= '0;
      end
    end else begin
      dl_valid_q  <= {dl_valid_q[Depth-2:0], push_valid};
      dl_exp_q[0] <= push_exp;
      dl_idx_q[0] <= vec_d;
      for (int i = 1; i < int'(Depth); i++) begin
        dl_exp_q[i] <= dl_exp_q[i-1];
        dl_idx_q[i] <= dl_idx_q[i-1];
      end
    end
  end

  // Drive outputs come straight from the vector register: 0 after reset, last vector held
  // through DRAIN and DONE.
  assign adder.A_drv   = vec_q[WIDTH-1:0];
  assign adder.B_drv   = vec_q[2*WIDTH-1:WIDTH];
  assign adder.Cin_drv = vec_q[2*WIDTH];

  assign busy            = (state_q == StRun) || (state_q == StDrain);
  assign done            = (state_q == StDone);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_vec   = fev_q;
  assign first_err_valid = fevalid_q;

endmodule

// File: tb/tb_cla_self_test.sv
module tb_cla_self_test;
  localparam int W = 5;
  localparam int N = 1 << (2 * W + 1);
  localparam int L = 2;
  localparam int MaxCycles = 3000;

  logic CLK = 1'b0;
  logic RST;
  logic start;
  logic start3;

  always #5 CLK = ~CLK;

  cla_self_test_if #(.WIDTH(W)) bus ();
  cla_self_test_if #(.WIDTH(W)) bus3 ();

  logic              busy, done, pass, fevalid;
  logic [2*W+1:0]    err_count;
  logic [2*W:0]      fev;
  logic              busy3, done3, pass3, fevalid3;
  logic [2*W+1:0]    err_count3;
  logic [2*W:0]      fev3;

  cla_self_test #(.WIDTH(W), .LATENCY(L)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .start           (start),
    .adder           (bus),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_vec   (fev),
    .first_err_valid (fevalid)
  );

  cla_self_test #(.WIDTH(W), .LATENCY(3)) dut3 (
    .CLK             (CLK),
    .RST             (RST),
    .start           (start3),
    .adder           (bus3),
    .busy            (busy3),
    .done            (done3),
    .pass            (pass3),
    .err_count       (err_count3),
    .first_err_vec   (fev3),
    .first_err_valid (fevalid3)
  );

  // Registered adder under test for the main engine: input register, output register,
  // optional extra stage, optional stuck-at fault on one result bit.
  int        fault_bit = -1;
  logic      fault_val = 1'b0;
  logic      lat3 = 1'b0;
  logic [W-1:0] ma_q, mb_q;
  logic         mc_q;
  logic [W:0]   m1_q, m2_q, mobs;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ma_q <= '0; mb_q <= '0; mc_q <= 1'b0; m1_q <= '0; m2_q <= '0;
    end else begin
      ma_q <= bus.A_drv;
      mb_q <= bus.B_drv;
      mc_q <= bus.Cin_drv;
      m1_q <= {1'b0, ma_q} + {1'b0, mb_q} + {{W{1'b0}}, mc_q};
      m2_q <= m1_q;
    end
  end

  always_comb begin
    mobs = lat3 ? m2_q : m1_q;
    if (fault_bit >= 0 && fault_bit <= W) mobs[fault_bit] = fault_val;
    bus.S_obs    = mobs[W-1:0];
    bus.Cout_obs = mobs[W];
  end

  // Ideal 3-cycle adder for the LATENCY=3 engine.
  logic [W-1:0] pa_q, pb_q;
  logic         pc_q;
  logic [W:0]   p1_q, p2_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pa_q <= '0; pb_q <= '0; pc_q <= 1'b0; p1_q <= '0; p2_q <= '0;
    end else begin
      pa_q <= bus3.A_drv;
      pb_q <= bus3.B_drv;
      pc_q <= bus3.Cin_drv;
      p1_q <= {1'b0, pa_q} + {1'b0, pb_q} + {{W{1'b0}}, pc_q};
      p2_q <= p1_q;
    end
  end

  assign bus3.S_obs    = p2_q[W-1:0];
  assign bus3.Cout_obs = p2_q[W];

  int n_cmp = 0;
  int n_fail = 0;

  // Reference: what the faulty adder returns for vector v, from plain arithmetic.
  function automatic int ref_sum(int v, int fb, int fv);
    int a, b, c, s;
    a = v % (1 << W);
    b = (v / (1 << W)) % (1 << W);
    c = v / (1 << (2 * W));
    s = a + b + c;
    if (fb >= 0) s = (fv != 0) ? (s | (1 << fb)) : (s & ~(1 << fb));
    return s;
  endfunction

  task automatic ref_sweep(input int fb, input int fv, output int cnt, output int first);
    cnt = 0;
    first = -1;
    for (int v = 0; v < N; v++) begin
      if (ref_sum(v, fb, fv) != ref_sum(v, -1, 0)) begin
        cnt++;
        if (first < 0) first = v;
      end
    end
  endtask

  // Pulse start (sampled at edge e0), then count edges until done. Optionally re-pulse
  // start after pulse_at cycles of the sweep.
  task automatic run_sweep(input int pulse_at, output int cycles);
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_at_e0: got %b want 1", busy);
    end
    cycles = 0;
    while (done !== 1'b1 && cycles < MaxCycles) begin
      start = (cycles == pulse_at);
      @(posedge CLK);
      #1;
      cycles++;
    end
    start = 1'b0;
  endtask

  task automatic check_ideal(input string tag, input int cycles);
    n_cmp++;
    if (cycles !== N + L + 1) begin
      n_fail++;
      $display("FAIL %s_cycles: got %0d want %0d", tag, cycles, N + L + 1);
    end
    n_cmp++;
    if ({done, pass, fevalid} !== 3'b110) begin
      n_fail++;
      $display("FAIL %s_flags: got done/pass/fev_valid %b%b%b want 110", tag, done, pass,
               fevalid);
    end
    n_cmp++;
    if (err_count !== '0) begin
      n_fail++;
      $display("FAIL %s_err_count: got %0d want 0", tag, err_count);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if ({busy, done, pass, fevalid, err_count, fev, bus.A_drv, bus.B_drv, bus.Cin_drv} !== '0)
    begin
      n_fail++;
      $display("FAIL %s: got busy=%b done=%b pass=%b err=%0d fev=%0d fevv=%b A=%0d B=%0d C=%b want all 0",
               tag, busy, done, pass, err_count, fev, fevalid, bus.A_drv, bus.B_drv,
               bus.Cin_drv);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    start = 1'b0;
    start3 = 1'b0;
    #1;
    check_all_zero("reset_outputs");
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("idle_outputs");
  endtask

  task automatic test_ideal();
    int c;
    run_sweep(-1, c);
    check_ideal("ideal", c);
    n_cmp++;
    if ({bus.Cin_drv, bus.B_drv, bus.A_drv} !== {(2*W+1){1'b1}}) begin
      n_fail++;
      $display("FAIL hold_last_vec: got %0d want %0d", {bus.Cin_drv, bus.B_drv, bus.A_drv},
               N - 1);
    end
  endtask

  task automatic test_start_during_run();
    int c;
    run_sweep(int'($urandom_range(2000, 1)), c);
    check_ideal("start_in_run", c);
  endtask

  task automatic test_fault(input string tag, input int fb, input int fv);
    int c, cnt, first;
    fault_bit = fb;
    fault_val = fv[0];
    ref_sweep(fb, fv, cnt, first);
    run_sweep(-1, c);
    n_cmp++;
    if (int'(err_count) !== cnt) begin
      n_fail++;
      $display("FAIL %s_err_count: got %0d want %0d (bit %0d stuck %0d)", tag, err_count, cnt,
               fb, fv);
    end
    n_cmp++;
    if (int'(fev) !== first || fevalid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_first_err: got vec %0d valid %b want vec %0d valid 1", tag, fev,
               fevalid, first);
    end
    n_cmp++;
    if (pass !== 1'b0 || done !== 1'b1 || c !== N + L + 1) begin
      n_fail++;
      $display("FAIL %s_status: got pass %b done %b cycles %0d want 0 1 %0d", tag, pass, done, c,
               N + L + 1);
    end
    fault_bit = -1;
  endtask

  task automatic test_random_faults();
    for (int i = 0; i < 2; i++) begin
      test_fault("rand_fault", int'($urandom_range(W, 0)), int'($urandom_range(1, 0)));
    end
  endtask

  task automatic test_rerun_clean();
    int c;
    fault_bit = -1;
    run_sweep(-1, c);
    check_ideal("rerun_clean", c);
  endtask

  task automatic test_latency();
    int c;
    lat3 = 1'b1;
    run_sweep(-1, c);
    n_cmp++;
    if (pass !== 1'b0 || err_count == '0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_mismatch: got pass %b err %0d done %b want pass 0 err >0 done 1", pass,
               err_count, done);
    end
    lat3 = 1'b0;
    @(negedge CLK);
    start3 = 1'b1;
    @(posedge CLK);
    #1;
    start3 = 1'b0;
    c = 0;
    while (done3 !== 1'b1 && c < MaxCycles) begin
      @(posedge CLK);
      #1;
      c++;
    end
    n_cmp++;
    if (c !== N + 3 + 1 || pass3 !== 1'b1 || err_count3 !== '0 || fevalid3 !== 1'b0) begin
      n_fail++;
      $display("FAIL lat3_match: got cycles %0d pass %b err %0d fevv %b want %0d 1 0 0", c,
               pass3, err_count3, fevalid3, N + 4);
    end
  endtask

  task automatic test_reset_mid_run();
    int c;
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (500) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check_all_zero("reset_mid_run");
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    run_sweep(-1, c);
    check_ideal("after_reset", c);
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_start_during_run();
    test_fault("stuck_s0", 0, 0);
    test_fault("stuck_cout", W, 0);
    test_random_faults();
    test_rerun_clean();
    test_latency();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
